// File: rtl/pipe_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : pipe_hazard_scoreboard
// Brief  : In-flight write scoreboard that generates the operand bypass
//          selects, the load-use stall and the post-branch IF/ID flush.
// Rev    : 1.0  initial release
// ============================================================================
module pipe_hazard_scoreboard #(
    parameter int REG_W      = 5,
    parameter int NUM_STAGES = 3,
    parameter int LOAD_READY = 2,
    parameter int FLUSH_CYC  = 1,
    parameter int SEL_W      = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wr_en,
    input  logic [REG_W-1:0] id_wr_reg,
    input  logic             id_is_load,
    input  logic             br_taken,
    output logic             stall,
    output logic             flush_ifid,
    output logic [SEL_W-1:0] fwd_sel_rs,
    output logic [SEL_W-1:0] fwd_sel_rt,
    output logic [3:0]       inflight_cnt
);

    logic [NUM_STAGES:1] r_valid;
    logic [NUM_STAGES:1] r_load;
    logic [REG_W-1:0]    r_wreg [1:NUM_STAGES];
    logic [1:0]          r_fcnt;
    logic [3:0]          r_cnt;

    logic                w_accept;
    logic                w_haz_rs;
    logic                w_haz_rt;
    logic [SEL_W-1:0]    w_sel_rs;
    logic [SEL_W-1:0]    w_sel_rt;
    logic [NUM_STAGES:1] w_valid_nxt;
    logic [3:0]          w_cnt_nxt;

    // Scans oldest to youngest so the smallest matching stage wins.
    // Result is {load_hazard, select}.
    function automatic logic [SEL_W:0] f_match(input logic use_x,
                                               input logic [REG_W-1:0] x);
        logic [SEL_W:0] res;
        res = '0;
        for (int k = NUM_STAGES; k >= 1; k--) begin
            if (use_x && (x != '0) && r_valid[k] && (r_wreg[k] == x)) begin
                res = {(r_load[k] && (k < LOAD_READY)), SEL_W'(k)};
            end
        end
        return res;
    endfunction

    always_comb begin
        {w_haz_rs, w_sel_rs} = f_match(id_use_rs, id_rs);
        {w_haz_rt, w_sel_rt} = f_match(id_use_rt, id_rt);
    end

    assign flush_ifid = (r_fcnt != 2'd0);
    assign stall      = id_valid && !flush_ifid && (w_haz_rs || w_haz_rt);
    assign w_accept   = id_valid && !stall && !flush_ifid;
    assign fwd_sel_rs = w_sel_rs;
    assign fwd_sel_rt = w_sel_rt;
    assign inflight_cnt = r_cnt;

    assign w_valid_nxt = {r_valid[NUM_STAGES-1:1], (w_accept && id_wr_en)};

    always_comb begin
        w_cnt_nxt = '0;
        for (int k = 1; k <= NUM_STAGES; k++) begin
            w_cnt_nxt = w_cnt_nxt + {3'b000, w_valid_nxt[k]};
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_valid <= '0;
            r_load  <= '0;
            for (int k = 1; k <= NUM_STAGES; k++) begin
                r_wreg[k] <= '0;
            end
            r_fcnt  <= 2'd0;
            r_cnt   <= 4'd0;
        end else begin
            r_valid   <= w_valid_nxt;
            r_load    <= {r_load[NUM_STAGES-1:1], id_is_load};
            r_wreg[1] <= id_wr_reg;
            for (int k = 2; k <= NUM_STAGES; k++) begin
                r_wreg[k] <= r_wreg[k-1];
            end
            r_cnt <= w_cnt_nxt;
            // A branch can only be accepted when no flush is pending.
            if (r_fcnt != 2'd0) begin
                r_fcnt <= r_fcnt - 2'd1;
            end else if (br_taken && w_accept) begin
                r_fcnt <= 2'(FLUSH_CYC);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : tb_pipe_hazard_scoreboard
// Brief  : Scoreboard bench for pipe_hazard_scoreboard (FLUSH_CYC=2 build).
// Rev    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_scoreboard;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0;
    logic       id_wr_en = 1'b0, id_is_load = 1'b0, br_taken = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_wr_reg = '0;
    logic       stall, flush_ifid;
    logic [1:0] fwd_sel_rs, fwd_sel_rt;
    logic [3:0] inflight_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       we;
        logic [4:0] wr;
        logic       ld;
        logic       br;
    } stim_t;

    typedef struct packed {
        logic       stall;
        logic       flush;
        logic [1:0] rs;
        logic [1:0] rt;
        logic [3:0] cnt;
    } exp_t;

    exp_t q[$];

    pipe_hazard_scoreboard #(
        .REG_W(5), .NUM_STAGES(3), .LOAD_READY(2), .FLUSH_CYC(2), .SEL_W(2)
    ) dut (
        .Clk(Clk), .Rst(Rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
        .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .br_taken(br_taken),
        .stall(stall), .flush_ifid(flush_ifid), .fwd_sel_rs(fwd_sel_rs),
        .fwd_sel_rt(fwd_sel_rt), .inflight_cnt(inflight_cnt)
    );

    always #5 Clk = ~Clk;

    function automatic stim_t mk(input logic v, input int rs, input int rt,
                                 input logic urs, input logic urt, input logic we,
                                 input int wr, input logic ld, input logic br);
        stim_t s;
        s.v = v; s.rs = 5'(rs); s.rt = 5'(rt); s.urs = urs; s.urt = urt;
        s.we = we; s.wr = 5'(wr); s.ld = ld; s.br = br;
        return s;
    endfunction

    function automatic exp_t mke(input logic st, input logic fl, input int rs,
                                 input int rt, input int cnt);
        exp_t e;
        e.stall = st; e.flush = fl; e.rs = 2'(rs); e.rt = 2'(rt); e.cnt = 4'(cnt);
        return e;
    endfunction

    function automatic exp_t obs();
        return {stall, flush_ifid, fwd_sel_rs, fwd_sel_rt, inflight_cnt};
    endfunction

    task automatic drive(input stim_t s);
        id_valid = s.v; id_rs = s.rs; id_rt = s.rt; id_use_rs = s.urs;
        id_use_rt = s.urt; id_wr_en = s.we; id_wr_reg = s.wr;
        id_is_load = s.ld; br_taken = s.br;
    endtask

    task automatic drain();
        drive('0);
        repeat (4) begin
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_reset();
        exp_t  got, ex;
        stim_t s[4];
        exp_t  e[4];
        drive('0);
        q.push_back(mke(0, 0, 0, 0, 0));
        @(negedge Clk);
        got = obs(); ex = q.pop_front(); checks++;
        if (got !== ex) begin
            failures++;
            $display("FAIL reset_hold: got %b expected %b", got, ex);
        end
        @(posedge Clk); #1;
        Rst = 1'b0;
        s[0] = mk(1, 0, 0, 0, 0, 1, 1, 0, 0); e[0] = mke(0, 0, 0, 0, 0);
        s[1] = mk(1, 0, 0, 0, 0, 1, 2, 0, 0); e[1] = mke(0, 0, 0, 0, 1);
        s[2] = mk(1, 0, 0, 0, 0, 1, 3, 0, 0); e[2] = mke(0, 0, 0, 0, 2);
        s[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); e[3] = mke(0, 0, 0, 0, 3);
        for (int i = 0; i < 4; i++) begin
            drive(s[i]);
            q.push_back(e[i]);
            @(negedge Clk);
            got = obs(); ex = q.pop_front(); checks++;
            if (got !== ex) begin
                failures++;
                $display("FAIL reset_fill step%0d: got %b expected %b", i, got, ex);
            end
            @(posedge Clk); #1;
        end
        Rst = 1'b1;
        q.push_back(mke(0, 0, 0, 0, 0));
        #2;
        got = obs(); ex = q.pop_front(); checks++;
        if (got !== ex) begin
            failures++;
            $display("FAIL reset_async: got %b expected %b", got, ex);
        end
        Rst = 1'b0;
        drive(mk(1, 3, 2, 1, 1, 0, 0, 0, 0));
        q.push_back(mke(0, 0, 0, 0, 0));
        @(negedge Clk);
        got = obs(); ex = q.pop_front(); checks++;
        if (got !== ex) begin
            failures++;
            $display("FAIL reset_after_reader: got %b expected %b", got, ex);
        end
        @(posedge Clk); #1;
        drain();
    endtask

    task automatic test_alu_chain();
        exp_t  got, ex;
        stim_t s[5];
        exp_t  e[5];
        s[0] = mk(1, 1, 2, 1, 1, 1, 3, 0, 0); e[0] = mke(0, 0, 0, 0, 0);
        s[1] = mk(1, 3, 0, 1, 0, 1, 8, 0, 0); e[1] = mke(0, 0, 1, 0, 1);
        s[2] = mk(1, 0, 3, 0, 1, 0, 0, 0, 0); e[2] = mke(0, 0, 0, 2, 2);
        s[3] = mk(1, 3, 0, 1, 0, 0, 0, 0, 0); e[3] = mke(0, 0, 3, 0, 2);
        s[4] = mk(1, 3, 0, 1, 0, 0, 0, 0, 0); e[4] = mke(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            drive(s[i]);
            q.push_back(e[i]);
            @(negedge Clk);
            got = obs(); ex = q.pop_front(); checks++;
            if (got !== ex) begin
                failures++;
                $display("FAIL alu_chain step%0d: got %b expected %b", i, got, ex);
            end
            @(posedge Clk); #1;
        end
        drain();
    endtask

    task automatic test_load_use();
        exp_t  got, ex;
        stim_t s[4];
        exp_t  e[4];
        s[0] = mk(1, 0, 0, 0, 0, 1, 5, 1, 0); e[0] = mke(0, 0, 0, 0, 0);
        s[1] = mk(1, 5, 5, 1, 1, 1, 6, 0, 0); e[1] = mke(1, 0, 1, 1, 1);
        s[2] = mk(1, 5, 5, 1, 1, 1, 6, 0, 0); e[2] = mke(0, 0, 2, 2, 1);
        s[3] = mk(1, 6, 5, 1, 1, 0, 0, 0, 0); e[3] = mke(0, 0, 1, 3, 2);
        for (int i = 0; i < 4; i++) begin
            drive(s[i]);
            q.push_back(e[i]);
            @(negedge Clk);
            got = obs(); ex = q.pop_front(); checks++;
            if (got !== ex) begin
                failures++;
                $display("FAIL load_use step%0d: got %b expected %b", i, got, ex);
            end
            @(posedge Clk); #1;
        end
        drain();
    endtask

    task automatic test_youngest_and_gap();
        exp_t  got, ex;
        stim_t s[6];
        exp_t  e[6];
        s[0] = mk(1, 0, 0, 0, 0, 1, 7, 0, 0); e[0] = mke(0, 0, 0, 0, 0);
        s[1] = mk(1, 0, 0, 0, 0, 1, 7, 0, 0); e[1] = mke(0, 0, 0, 0, 1);
        s[2] = mk(1, 7, 7, 1, 1, 0, 0, 0, 0); e[2] = mke(0, 0, 1, 1, 2);
        s[3] = mk(1, 0, 0, 0, 0, 1, 9, 1, 0); e[3] = mke(0, 0, 0, 0, 2);
        s[4] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0); e[4] = mke(0, 0, 0, 0, 2);
        s[5] = mk(1, 9, 0, 1, 0, 0, 0, 0, 0); e[5] = mke(0, 0, 2, 0, 1);
        for (int i = 0; i < 6; i++) begin
            drive(s[i]);
            q.push_back(e[i]);
            @(negedge Clk);
            got = obs(); ex = q.pop_front(); checks++;
            if (got !== ex) begin
                failures++;
                $display("FAIL youngest_gap step%0d: got %b expected %b", i, got, ex);
            end
            @(posedge Clk); #1;
        end
        drain();
    endtask

    task automatic test_branch_flush();
        exp_t  got, ex;
        stim_t s[5];
        exp_t  e[5];
        s[0] = mk(1, 0, 0, 0, 0, 1, 31, 0, 1); e[0] = mke(0, 0, 0, 0, 0);
        s[1] = mk(1, 0, 0, 0, 0, 1, 10, 0, 0); e[1] = mke(0, 1, 0, 0, 1);
        s[2] = mk(1, 0, 0, 0, 0, 1, 11, 0, 1); e[2] = mke(0, 1, 0, 0, 1);
        s[3] = mk(1, 10, 31, 1, 1, 1, 12, 0, 0); e[3] = mke(0, 0, 0, 3, 1);
        s[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); e[4] = mke(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            drive(s[i]);
            q.push_back(e[i]);
            @(negedge Clk);
            got = obs(); ex = q.pop_front(); checks++;
            if (got !== ex) begin
                failures++;
                $display("FAIL branch_flush step%0d: got %b expected %b", i, got, ex);
            end
            @(posedge Clk); #1;
        end
        drain();
    endtask

    task automatic test_stall_vs_branch();
        exp_t  got, ex;
        stim_t s[6];
        exp_t  e[6];
        s[0] = mk(1, 0, 0, 0, 0, 1, 4, 1, 0);  e[0] = mke(0, 0, 0, 0, 0);
        s[1] = mk(1, 4, 0, 1, 0, 0, 0, 0, 1);  e[1] = mke(1, 0, 1, 0, 1);
        s[2] = mk(1, 4, 0, 1, 0, 0, 0, 0, 1);  e[2] = mke(0, 0, 2, 0, 1);
        s[3] = mk(1, 0, 0, 0, 0, 1, 13, 0, 0); e[3] = mke(0, 1, 0, 0, 1);
        s[4] = mk(1, 0, 0, 0, 0, 1, 13, 0, 0); e[4] = mke(0, 1, 0, 0, 0);
        s[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);  e[5] = mke(0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            drive(s[i]);
            q.push_back(e[i]);
            @(negedge Clk);
            got = obs(); ex = q.pop_front(); checks++;
            if (got !== ex) begin
                failures++;
                $display("FAIL stall_vs_branch step%0d: got %b expected %b", i, got, ex);
            end
            @(posedge Clk); #1;
        end
        drain();
    endtask

    task automatic test_r0();
        exp_t  got, ex;
        stim_t s[4];
        exp_t  e[4];
        s[0] = mk(1, 0, 0, 0, 0, 1, 0, 0, 0); e[0] = mke(0, 0, 0, 0, 0);
        s[1] = mk(1, 0, 0, 1, 1, 0, 0, 0, 0); e[1] = mke(0, 0, 0, 0, 1);
        s[2] = mk(1, 0, 0, 1, 0, 1, 0, 1, 0); e[2] = mke(0, 0, 0, 0, 1);
        s[3] = mk(1, 0, 0, 1, 1, 0, 0, 0, 0); e[3] = mke(0, 0, 0, 0, 2);
        for (int i = 0; i < 4; i++) begin
            drive(s[i]);
            q.push_back(e[i]);
            @(negedge Clk);
            got = obs(); ex = q.pop_front(); checks++;
            if (got !== ex) begin
                failures++;
                $display("FAIL r0 step%0d: got %b expected %b", i, got, ex);
            end
            @(posedge Clk); #1;
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_alu_chain();
        test_load_use();
        test_youngest_and_gap();
        test_branch_flush();
        test_stall_vs_branch();
        test_r0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
